// File: rtl/hazard_ctrl.sv
// Forwarding and hazard controller for the 5-stage RISC-V pipeline: per-operand bypass
// selection, load-use stall sequencing, a single-entry MDU scoreboard and redirect arbitration.
module hazard_ctrl #(
    parameter int NRS      = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNTW     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [NRS*5-1:0]    id_rs,
    input  logic [NRS-1:0]      id_rs_used,
    input  logic                id_mdu,
    input  logic                ex_valid,
    input  logic                ex_regwrite,
    input  logic                ex_memread,
    input  logic                ex_mdu,
    input  logic [4:0]          ex_rd,
    input  logic                mem_valid,
    input  logic                mem_regwrite,
    input  logic [4:0]          mem_rd,
    input  logic                wb_valid,
    input  logic                wb_regwrite,
    input  logic [4:0]          wb_rd,
    input  logic                mdu_done,
    input  logic                redirect,
    output logic [NRS*2-1:0]    fd_mode,
    output logic                stall_if,
    output logic                stall_id,
    output logic                bubble_ex,
    output logic                flush_id,
    output logic                flush_ex,
    output logic                load_use,
    output logic [CNTW-1:0]     stall_cnt
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_LU_WAIT = 1'b1;

    localparam logic [1:0] LU_INIT = 2'(LOAD_LAT - 1);

    logic [0:0]      state_q;
    logic [1:0]      lu_cnt_q;
    logic            mdu_pend_q;
    logic [4:0]      mdu_rd_q;
    logic [CNTW-1:0] stall_cnt_q;

    logic lu_match;
    logic sb_match;
    logic lu_hit;
    logic sb_hit;
    logic mdu_struct;
    logic stall;
    logic mdu_issue;

    // Per-operand bypass selection plus the load-use and scoreboard RAW matches.
    // NOTE: every always_comb output gets a default before any conditional update, so no latch is inferred.
    always_comb begin
        fd_mode  = '0;
        lu_match = 1'b0;
        sb_match = 1'b0;
        for (int i = 0; i < NRS; i++) begin
            if (id_rs_used[i] && id_rs[5*i +: 5] != 5'd0) begin
                if (ex_valid && ex_regwrite && ex_rd == id_rs[5*i +: 5])
                    fd_mode[2*i +: 2] = 2'b01;
                else if (mem_valid && mem_regwrite && mem_rd == id_rs[5*i +: 5])
                    fd_mode[2*i +: 2] = 2'b10;
                else if (wb_valid && wb_regwrite && wb_rd == id_rs[5*i +: 5])
                    fd_mode[2*i +: 2] = 2'b11;

                if (ex_valid && ex_memread && ex_rd == id_rs[5*i +: 5])
                    lu_match = 1'b1;
                if (mdu_pend_q && mdu_rd_q == id_rs[5*i +: 5])
                    sb_match = 1'b1;
            end
        end
    end

    assign lu_hit     = (state_q == ST_IDLE) && id_valid && lu_match;
    assign sb_hit     = sb_match;
    assign mdu_struct = mdu_pend_q && id_valid && id_mdu;
    assign mdu_issue  = ex_valid && ex_mdu && ex_regwrite && !redirect;

    // Redirect overrides every stall source; reset forces all controls low.
    assign stall = !rst && !redirect &&
                   (lu_hit || state_q == ST_LU_WAIT || sb_hit || mdu_struct);

    assign stall_if  = stall;
    assign stall_id  = stall;
    assign bubble_ex = stall;
    assign flush_id  = !rst && redirect;
    assign flush_ex  = !rst && redirect;
    assign load_use  = !rst && !redirect && lu_hit;
    assign stall_cnt = rst ? '0 : stall_cnt_q;

    // Load-use FSM: the detection cycle stalls from IDLE, LU_WAIT covers the remaining LOAD_LAT-1 cycles.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            lu_cnt_q <= 2'd0;
        end else if (redirect) begin
            state_q  <= ST_IDLE;
            lu_cnt_q <= 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (lu_hit && LOAD_LAT > 1) begin
                        state_q  <= ST_LU_WAIT;
                        lu_cnt_q <= LU_INIT;
                    end
                end
                ST_LU_WAIT: begin
                    lu_cnt_q <= lu_cnt_q - 2'd1;
                    if (lu_cnt_q == 2'd1)
                        state_q <= ST_IDLE;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    lu_cnt_q <= 2'd0;
                end
            endcase
        end
    end

    // Single outstanding MDU result; a new issue in the same cycle as mdu_done keeps the entry live.
    always_ff @(posedge clk) begin
        if (rst) begin
            mdu_pend_q <= 1'b0;
            mdu_rd_q   <= 5'd0;
        end else if (mdu_issue) begin
            mdu_pend_q <= 1'b1;
            mdu_rd_q   <= ex_rd;
        end else if (mdu_done) begin
            mdu_pend_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_q <= '0;
        else if (stall && !(&stall_cnt_q))
            stall_cnt_q <= stall_cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (LOAD_LAT 1/3/2, the last with a 4-bit counter)
// share one stimulus stream; each scenario task checks against hand-computed values.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [9:0] id_rs;
    logic [1:0] id_rs_used;
    logic       id_mdu;
    logic       ex_valid, ex_regwrite, ex_memread, ex_mdu;
    logic [4:0] ex_rd;
    logic       mem_valid, mem_regwrite;
    logic [4:0] mem_rd;
    logic       wb_valid, wb_regwrite;
    logic [4:0] wb_rd;
    logic       mdu_done;
    logic       redirect;

    logic [3:0]  fd_l1, fd_l3, fd_c4;
    logic        sif_l1, sid_l1, bub_l1, fid_l1, fex_l1, lu_l1;
    logic        sif_l3, sid_l3, bub_l3, fid_l3, fex_l3, lu_l3;
    logic        sif_c4, sid_c4, bub_c4, fid_c4, fex_c4, lu_c4;
    logic [15:0] cnt_l1, cnt_l3;
    logic [3:0]  cnt_c4;
    logic [5:0]  ctl_l1, ctl_l3, ctl_c4;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    // Control bundle order: {stall_if, stall_id, bubble_ex, load_use, flush_id, flush_ex}
    assign ctl_l1 = {sif_l1, sid_l1, bub_l1, lu_l1, fid_l1, fex_l1};
    assign ctl_l3 = {sif_l3, sid_l3, bub_l3, lu_l3, fid_l3, fex_l3};
    assign ctl_c4 = {sif_c4, sid_c4, bub_c4, lu_c4, fid_c4, fex_c4};

    hazard_ctrl #(.NRS(2), .LOAD_LAT(1), .CNTW(16)) u_l1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_mdu(id_mdu), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_mdu(ex_mdu), .ex_rd(ex_rd), .mem_valid(mem_valid), .mem_regwrite(mem_regwrite),
        .mem_rd(mem_rd), .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .mdu_done(mdu_done), .redirect(redirect), .fd_mode(fd_l1), .stall_if(sif_l1),
        .stall_id(sid_l1), .bubble_ex(bub_l1), .flush_id(fid_l1), .flush_ex(fex_l1),
        .load_use(lu_l1), .stall_cnt(cnt_l1));

    hazard_ctrl #(.NRS(2), .LOAD_LAT(3), .CNTW(16)) u_l3 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_mdu(id_mdu), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_mdu(ex_mdu), .ex_rd(ex_rd), .mem_valid(mem_valid), .mem_regwrite(mem_regwrite),
        .mem_rd(mem_rd), .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .mdu_done(mdu_done), .redirect(redirect), .fd_mode(fd_l3), .stall_if(sif_l3),
        .stall_id(sid_l3), .bubble_ex(bub_l3), .flush_id(fid_l3), .flush_ex(fex_l3),
        .load_use(lu_l3), .stall_cnt(cnt_l3));

    hazard_ctrl #(.NRS(2), .LOAD_LAT(2), .CNTW(4)) u_c4 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_mdu(id_mdu), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_mdu(ex_mdu), .ex_rd(ex_rd), .mem_valid(mem_valid), .mem_regwrite(mem_regwrite),
        .mem_rd(mem_rd), .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .mdu_done(mdu_done), .redirect(redirect), .fd_mode(fd_c4), .stall_if(sif_c4),
        .stall_id(sid_c4), .bubble_ex(bub_c4), .flush_id(fid_c4), .flush_ex(fex_c4),
        .load_use(lu_c4), .stall_cnt(cnt_c4));

    task automatic clr;
        id_valid = 0; id_rs = '0; id_rs_used = '0; id_mdu = 0;
        ex_valid = 0; ex_regwrite = 0; ex_memread = 0; ex_mdu = 0; ex_rd = '0;
        mem_valid = 0; mem_regwrite = 0; mem_rd = '0;
        wb_valid = 0; wb_regwrite = 0; wb_rd = '0;
        mdu_done = 0; redirect = 0;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1; clr();
        tick(); tick();
        rst = 0;
    endtask

    // ID reads x1 on operand 0 while a load to x1 sits in EX.
    task automatic drive_load_use;
        id_valid = 1; id_rs = 10'd1; id_rs_used = 2'b01;
        ex_valid = 1; ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd1;
    endtask

    task automatic test_reset;
        rst = 1; clr();
        tick();
        drive_load_use();
        #2;
        vectors++; if (ctl_l1 !== 6'b0) begin errors++; $display("FAIL rst_ctl_l1: got %b want %b", ctl_l1, 6'b0); end
        vectors++; if (ctl_l3 !== 6'b0) begin errors++; $display("FAIL rst_ctl_l3: got %b want %b", ctl_l3, 6'b0); end
        vectors++; if (fd_l1 !== 4'b0001) begin errors++; $display("FAIL rst_fd: got %b want %b", fd_l1, 4'b0001); end
        tick(); #2;
        vectors++; if (cnt_l1 !== 16'd0) begin errors++; $display("FAIL rst_cnt_l1: got %0d want 0", cnt_l1); end
        vectors++; if (ctl_c4 !== 6'b0) begin errors++; $display("FAIL rst_ctl_c4: got %b want %b", ctl_c4, 6'b0); end
        rst = 0; clr();
        tick(); #2;
        vectors++; if (ctl_l3 !== 6'b0) begin errors++; $display("FAIL post_rst_ctl_l3: got %b want %b", ctl_l3, 6'b0); end
    endtask

    task automatic test_bypass;
        do_reset();
        id_valid = 1; id_rs = {5'd5, 5'd5}; id_rs_used = 2'b11;
        ex_valid = 1; ex_regwrite = 1; ex_rd = 5'd5;
        mem_valid = 1; mem_regwrite = 1; mem_rd = 5'd5;
        wb_valid = 1; wb_regwrite = 1; wb_rd = 5'd5;
        #2;
        vectors++; if (fd_l1 !== 4'b0101) begin errors++; $display("FAIL byp_ex: got %b want %b", fd_l1, 4'b0101); end
        vectors++; if (ctl_l1 !== 6'b0) begin errors++; $display("FAIL byp_nostall: got %b want %b", ctl_l1, 6'b0); end
        ex_valid = 0; #2;
        vectors++; if (fd_l1 !== 4'b1010) begin errors++; $display("FAIL byp_mem: got %b want %b", fd_l1, 4'b1010); end
        mem_regwrite = 0; #2;
        vectors++; if (fd_l3 !== 4'b1111) begin errors++; $display("FAIL byp_wb: got %b want %b", fd_l3, 4'b1111); end
        id_rs_used = 2'b01; #2;
        vectors++; if (fd_l3 !== 4'b0011) begin errors++; $display("FAIL byp_unused: got %b want %b", fd_l3, 4'b0011); end
        id_rs_used = 2'b11; ex_valid = 1; mem_regwrite = 1; ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
        id_rs = 10'd0; #2;
        vectors++; if (fd_c4 !== 4'b0000) begin errors++; $display("FAIL byp_x0: got %b want %b", fd_c4, 4'b0000); end
    endtask

    task automatic test_load_use;
        do_reset();
        drive_load_use(); #2;
        vectors++; if (ctl_l1 !== 6'b111100) begin errors++; $display("FAIL lu_c1_l1: got %b want %b", ctl_l1, 6'b111100); end
        vectors++; if (ctl_l3 !== 6'b111100) begin errors++; $display("FAIL lu_c1_l3: got %b want %b", ctl_l3, 6'b111100); end
        tick();
        ex_valid = 0; ex_memread = 0; ex_regwrite = 0;
        mem_valid = 1; mem_regwrite = 1; mem_rd = 5'd1; #2;
        vectors++; if (ctl_l1 !== 6'b0) begin errors++; $display("FAIL lu_c2_l1: got %b want %b", ctl_l1, 6'b0); end
        vectors++; if (fd_l1 !== 4'b0010) begin errors++; $display("FAIL lu_c2_fd: got %b want %b", fd_l1, 4'b0010); end
        vectors++; if (cnt_l1 !== 16'd1) begin errors++; $display("FAIL lu_cnt_l1: got %0d want 1", cnt_l1); end
        vectors++; if (ctl_l3 !== 6'b111000) begin errors++; $display("FAIL lu_c2_l3: got %b want %b", ctl_l3, 6'b111000); end
        vectors++; if (ctl_c4 !== 6'b111000) begin errors++; $display("FAIL lu_c2_c4: got %b want %b", ctl_c4, 6'b111000); end
        tick();
        mem_valid = 0; wb_valid = 1; wb_regwrite = 1; wb_rd = 5'd1; #2;
        vectors++; if (ctl_l3 !== 6'b111000) begin errors++; $display("FAIL lu_c3_l3: got %b want %b", ctl_l3, 6'b111000); end
        vectors++; if (ctl_c4 !== 6'b0) begin errors++; $display("FAIL lu_c3_c4: got %b want %b", ctl_c4, 6'b0); end
        vectors++; if (fd_c4 !== 4'b0011) begin errors++; $display("FAIL lu_c3_fd: got %b want %b", fd_c4, 4'b0011); end
        vectors++; if (cnt_c4 !== 4'd2) begin errors++; $display("FAIL lu_cnt_c4: got %0d want 2", cnt_c4); end
        tick();
        wb_valid = 0; #2;
        vectors++; if (ctl_l3 !== 6'b0) begin errors++; $display("FAIL lu_c4_l3: got %b want %b", ctl_l3, 6'b0); end
        vectors++; if (cnt_l3 !== 16'd3) begin errors++; $display("FAIL lu_cnt_l3: got %0d want 3", cnt_l3); end
    endtask

    task automatic test_redirect;
        do_reset();
        drive_load_use(); #2;
        vectors++; if (ctl_l3 !== 6'b111100) begin errors++; $display("FAIL rd_c1_l3: got %b want %b", ctl_l3, 6'b111100); end
        tick();
        ex_valid = 0; ex_memread = 0; ex_regwrite = 0;
        mem_valid = 1; mem_regwrite = 1; mem_rd = 5'd1; redirect = 1; #2;
        vectors++; if (ctl_l3 !== 6'b000011) begin errors++; $display("FAIL rd_c2_l3: got %b want %b", ctl_l3, 6'b000011); end
        tick();
        redirect = 0; id_valid = 0; id_rs_used = 2'b00; mem_valid = 0; #2;
        vectors++; if (ctl_l3 !== 6'b0) begin errors++; $display("FAIL rd_idle_l3: got %b want %b", ctl_l3, 6'b0); end
        vectors++; if (cnt_l3 !== 16'd1) begin errors++; $display("FAIL rd_cnt_l3: got %0d want 1", cnt_l3); end
        tick();
        drive_load_use(); redirect = 1; #2;
        vectors++; if (ctl_l3 !== 6'b000011) begin errors++; $display("FAIL rd_lu_same: got %b want %b", ctl_l3, 6'b000011); end
        tick();
        redirect = 0; ex_valid = 0; ex_memread = 0; ex_regwrite = 0; #2;
        vectors++; if (ctl_l3 !== 6'b0) begin errors++; $display("FAIL rd_lu_next: got %b want %b", ctl_l3, 6'b0); end
    endtask

    task automatic test_mdu;
        do_reset();
        id_valid = 1; ex_valid = 1; ex_mdu = 1; ex_regwrite = 1; ex_rd = 5'd7; #2;
        vectors++; if (ctl_l1 !== 6'b0) begin errors++; $display("FAIL mdu_issue: got %b want %b", ctl_l1, 6'b0); end
        tick();
        ex_valid = 0; ex_mdu = 0; ex_regwrite = 0; id_rs = 10'd7; id_rs_used = 2'b01; #2;
        vectors++; if (ctl_l1 !== 6'b111000) begin errors++; $display("FAIL mdu_raw: got %b want %b", ctl_l1, 6'b111000); end
        tick();
        id_rs_used = 2'b00; id_mdu = 1; #2;
        vectors++; if (ctl_l3 !== 6'b111000) begin errors++; $display("FAIL mdu_struct: got %b want %b", ctl_l3, 6'b111000); end
        tick();
        id_rs_used = 2'b01; id_mdu = 0; mdu_done = 1; #2;
        vectors++; if (ctl_l1 !== 6'b111000) begin errors++; $display("FAIL mdu_done_cyc: got %b want %b", ctl_l1, 6'b111000); end
        tick();
        mdu_done = 0; wb_valid = 1; wb_regwrite = 1; wb_rd = 5'd7; #2;
        vectors++; if (ctl_l1 !== 6'b0) begin errors++; $display("FAIL mdu_release: got %b want %b", ctl_l1, 6'b0); end
        vectors++; if (fd_l1 !== 4'b0011) begin errors++; $display("FAIL mdu_fd_wb: got %b want %b", fd_l1, 4'b0011); end
        vectors++; if (cnt_l1 !== 16'd3) begin errors++; $display("FAIL mdu_cnt: got %0d want 3", cnt_l1); end
        tick();
        wb_valid = 0; id_valid = 0; id_rs_used = 2'b00;
        ex_valid = 1; ex_mdu = 1; ex_regwrite = 1; ex_rd = 5'd7;
        tick();
        ex_rd = 5'd9; mdu_done = 1; #2;
        vectors++; if (ctl_l1 !== 6'b0) begin errors++; $display("FAIL mdu_swap_cyc: got %b want %b", ctl_l1, 6'b0); end
        tick();
        ex_valid = 0; ex_mdu = 0; ex_regwrite = 0; mdu_done = 0;
        id_valid = 1; id_rs = 10'd9; id_rs_used = 2'b01; #2;
        vectors++; if (ctl_l1 !== 6'b111000) begin errors++; $display("FAIL mdu_swap_new: got %b want %b", ctl_l1, 6'b111000); end
        id_rs = 10'd7; #2;
        vectors++; if (ctl_l1 !== 6'b0) begin errors++; $display("FAIL mdu_swap_old: got %b want %b", ctl_l1, 6'b0); end
        tick();
        id_valid = 0; id_rs_used = 2'b00; mdu_done = 1;
        tick();
        mdu_done = 0; ex_valid = 1; ex_mdu = 1; ex_regwrite = 1; ex_rd = 5'd9; redirect = 1; #2;
        vectors++; if (ctl_l1 !== 6'b000011) begin errors++; $display("FAIL mdu_redir_cyc: got %b want %b", ctl_l1, 6'b000011); end
        tick();
        ex_valid = 0; ex_mdu = 0; ex_regwrite = 0; redirect = 0;
        id_valid = 1; id_rs = 10'd9; id_rs_used = 2'b01; #2;
        vectors++; if (ctl_l1 !== 6'b0) begin errors++; $display("FAIL mdu_redir_noset: got %b want %b", ctl_l1, 6'b0); end
    endtask

    task automatic test_saturation;
        do_reset();
        ex_valid = 1; ex_mdu = 1; ex_regwrite = 1; ex_rd = 5'd7;
        tick();
        ex_valid = 0; ex_mdu = 0; ex_regwrite = 0;
        id_valid = 1; id_rs = 10'd7; id_rs_used = 2'b01;
        for (int k = 0; k < 20; k++) tick();
        #2;
        vectors++; if (cnt_c4 !== 4'd15) begin errors++; $display("FAIL sat_c4: got %0d want 15", cnt_c4); end
        vectors++; if (cnt_l1 !== 16'd20) begin errors++; $display("FAIL sat_l1: got %0d want 20", cnt_l1); end
        vectors++; if (ctl_c4 !== 6'b111000) begin errors++; $display("FAIL sat_stall: got %b want %b", ctl_c4, 6'b111000); end
        rst = 1; #2;
        vectors++; if (ctl_c4 !== 6'b0) begin errors++; $display("FAIL rst_mid_ctl: got %b want %b", ctl_c4, 6'b0); end
        vectors++; if (cnt_c4 !== 4'd0) begin errors++; $display("FAIL rst_mid_cnt: got %0d want 0", cnt_c4); end
        tick();
        rst = 0; #2;
        vectors++; if (ctl_l1 !== 6'b0) begin errors++; $display("FAIL rst_mid_after: got %b want %b", ctl_l1, 6'b0); end
        vectors++; if (cnt_l1 !== 16'd0) begin errors++; $display("FAIL rst_mid_cnt_l1: got %0d want 0", cnt_l1); end
    endtask

    initial begin
        rst = 1;
        clr();
        test_reset();
        test_bypass();
        test_load_use();
        test_redirect();
        test_mdu();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
